bp_be_fp_recode_pipe: RTL and testbench

Two-stage pipelined converter from IEEE-754 register-file data (FP load data, `fmv.*.x` sources) to the backend's tagged recoded floating-point register format, `bp_be_fp_reg_s`. It consumes raw 64-bit words plus a precision tag, NaN-box checks single-precision values, and widens SP to the DP-recoded container. It emits 66-bit `bp_be_fp_reg_s` words for FP register-file writeback. It sits directly upstream of every consumer of `bp_be_fp_reg_s`.

---
 rtl/bp_be_pkg.sv | 66 ++++++
 rtl/bp_be_fp_unpack.sv | 57 +++++
 rtl/bp_be_fp_recode_pipe.sv | 111 +++++++++++
 tb/tb_bp_be_fp_recode_pipe.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Backend FP shared definitions: widths, recoded-exponent constants, tag and
// class enums, the tagged recoded register format and the unpack payload.
package bp_be_pkg;

  localparam int unsigned dpath_width_gp     = 66;
  localparam int unsigned dp_rec_width_gp    = 65;
  localparam int unsigned rec_exp_width_gp   = 12;
  localparam int unsigned fract_width_gp     = 52;
  localparam int unsigned reg_addr_width_gp  = 5;
  localparam int unsigned lz_width_gp        = 6;

  localparam int unsigned dp_rec_bias_gp = 1025;
  localparam int unsigned sp_rec_bias_gp = 1921;

  localparam logic [rec_exp_width_gp-1:0] rec_exp_inf_gp = 12'hc00;
  localparam logic [rec_exp_width_gp-1:0] rec_exp_nan_gp = 12'he00;

  typedef enum logic {
    e_fp_dp = 1'b0,
    e_fp_sp = 1'b1
  } bp_be_fp_tag_e;

  typedef enum logic [2:0] {
    e_fp_zero = 3'd0,
    e_fp_sub  = 3'd1,
    e_fp_norm = 3'd2,
    e_fp_inf  = 3'd3,
    e_fp_nan  = 3'd4
  } bp_be_fp_class_e;

  typedef struct packed {
    bp_be_fp_tag_e                tag;
    logic                         sign;
    logic [rec_exp_width_gp-1:0]  exp;
    logic [fract_width_gp-1:0]    fract;
  } bp_be_fp_reg_s;

  // Stage-1 payload; SP fractions are left-aligned into the 52-bit field
  typedef struct packed {
    bp_be_fp_tag_e                tag;
    logic                         sign;
    bp_be_fp_class_e              cls;
    logic [10:0]                  exp;
    logic [fract_width_gp-1:0]    fract;
    logic [lz_width_gp-1:0]       lz;
    logic                         unboxed;
    logic [reg_addr_width_gp-1:0] rd_addr;
  } bp_be_fp_unpack_s;

  // Canonical quiet NaN substituted for SP values that fail the NaN-box check
  localparam bp_be_fp_reg_s sp_canonical_reg = '{
    tag:   e_fp_sp,
    sign:  1'b0,
    exp:   rec_exp_nan_gp,
    fract: 52'h8_0000_0000_0000
  };

  // Leading-zero count of a 52-bit field; returns 52 for an all-zero input
  function automatic logic [lz_width_gp-1:0] clz52(input logic [fract_width_gp-1:0] f);
    clz52 = 6'd52;
    for (int i = 0; i < 52; i++) begin
      if (f[i]) clz52 = 6'(51 - i);
    end
  endfunction

endpackage

// File: rtl/bp_be_fp_unpack.sv
// Stage-1 combinational unpack: field split, classification, NaN-box check
// and leading-zero count of the (left-aligned) fraction.
//   data_i    raw IEEE bits (SP in [31:0], NaN-boxed by [63:32])
//   tag_i     precision tag
//   rd_addr_i destination register, carried in the payload
//   unpack_o  stage-1 payload
module bp_be_fp_unpack
  import bp_be_pkg::*;
(
  input  logic [63:0]                  data_i,
  input  bp_be_fp_tag_e                tag_i,
  input  logic [reg_addr_width_gp-1:0] rd_addr_i,
  output bp_be_fp_unpack_s             unpack_o
);

  logic                      is_sp;
  logic                      sign;
  logic [10:0]               exp;
  logic [fract_width_gp-1:0] fract;
  logic                      exp_max;
  bp_be_fp_class_e           cls;

  assign is_sp = (tag_i == e_fp_sp);

  // Field extraction; SP fraction left-aligned so one 52-bit clz serves both
  always_comb begin
    sign    = data_i[63];
    exp     = data_i[62:52];
    fract   = data_i[51:0];
    exp_max = &data_i[62:52];
    if (is_sp) begin
      sign    = data_i[31];
      exp     = 11'(data_i[30:23]);
      fract   = {data_i[22:0], 29'b0};
      exp_max = &data_i[30:23];
    end
  end

  always_comb begin
    cls = e_fp_norm;
    if (exp == 11'd0)  cls = (fract == '0) ? e_fp_zero : e_fp_sub;
    else if (exp_max)  cls = (fract == '0) ? e_fp_inf  : e_fp_nan;
  end

  always_comb begin
    unpack_o         = '0;
    unpack_o.tag     = tag_i;
    unpack_o.sign    = sign;
    unpack_o.cls     = cls;
    unpack_o.exp     = exp;
    unpack_o.fract   = fract;
    unpack_o.lz      = clz52(fract);
    unpack_o.unboxed = is_sp & (data_i[63:32] != 32'hffff_ffff);
    unpack_o.rd_addr = rd_addr_i;
  end

endmodule

// File: rtl/bp_be_fp_recode_pipe.sv
// Two-stage IEEE-754 to tagged-recoded FP converter with valid/ready flow.
//   clk_i, reset_i          clock, synchronous active-high reset
//   v_i, ready_and_o        input handshake
//   data_i, tag_i, rd_addr_i raw operand, precision tag, destination
//   flush_i                 drop all in-flight entries
//   v_o, ready_and_i        output handshake
//   data_o                  bp_be_fp_reg_s result
//   rd_addr_o, unboxed_o    passed-through destination, NaN-box failure flag
module bp_be_fp_recode_pipe
  import bp_be_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  output logic                         ready_and_o,
  input  logic [63:0]                  data_i,
  input  bp_be_fp_tag_e                tag_i,
  input  logic [reg_addr_width_gp-1:0] rd_addr_i,
  input  logic                         flush_i,
  output logic                         v_o,
  input  logic                         ready_and_i,
  output logic [dpath_width_gp-1:0]    data_o,
  output logic [reg_addr_width_gp-1:0] rd_addr_o,
  output logic                         unboxed_o
);

  logic                         v1_r, v2_r;
  logic                         s2_ready, accept, adv;
  bp_be_fp_unpack_s             s1_n, s1_r;
  bp_be_fp_reg_s                rec_c, data_r;
  logic [reg_addr_width_gp-1:0] rd_addr_r;
  logic                         unboxed_r;
  logic [lz_width_gp-1:0]       shamt;
  logic [fract_width_gp-1:0]    fract_sh;
  logic [rec_exp_width_gp-1:0]  bias;

  bp_be_fp_unpack unpack (
    .data_i    (data_i),
    .tag_i     (tag_i),
    .rd_addr_i (rd_addr_i),
    .unpack_o  (s1_n)
  );

  // Stage 2 can take a new entry when empty or draining this cycle
  assign s2_ready    = !v2_r | ready_and_i;
  assign ready_and_o = !v1_r | s2_ready;
  assign accept      = v_i & ready_and_o;
  assign adv         = v1_r & s2_ready;

  // Valid bits
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
    end else begin
      if (ready_and_o) v1_r <= v_i;
      if (s2_ready)    v2_r <= v1_r;
    end
  end

  // Stage-1 payload register
  always_ff @(posedge clk_i) begin
    if (accept) s1_r <= s1_n;
  end

  // Stage-2 recode; subnormals normalise by shifting out the leading one
  always_comb begin
    shamt    = 6'(s1_r.lz + 6'd1);
    fract_sh = s1_r.fract << shamt;
    bias     = (s1_r.tag == e_fp_sp) ? 12'(sp_rec_bias_gp) : 12'(dp_rec_bias_gp);
    rec_c       = '0;
    rec_c.tag   = s1_r.tag;
    rec_c.sign  = s1_r.sign;
    case (s1_r.cls)
      e_fp_sub: begin
        rec_c.exp   = bias - 12'(s1_r.lz);
        rec_c.fract = fract_sh;
      end
      e_fp_norm: begin
        rec_c.exp   = bias + 12'(s1_r.exp);
        rec_c.fract = s1_r.fract;
      end
      e_fp_inf: rec_c.exp = rec_exp_inf_gp;
      e_fp_nan: begin
        rec_c.exp   = rec_exp_nan_gp;
        rec_c.fract = s1_r.fract;
      end
      default: ;
    endcase
    if (s1_r.unboxed) rec_c = sp_canonical_reg;
  end

  // Stage-2 output registers; held while stalled
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_r    <= '0;
      rd_addr_r <= '0;
      unboxed_r <= 1'b0;
    end else if (adv) begin
      data_r    <= rec_c;
      rd_addr_r <= s1_r.rd_addr;
      unboxed_r <= s1_r.unboxed;
    end
  end

  assign v_o       = v2_r;
  assign data_o    = data_r;
  assign rd_addr_o = rd_addr_r;
  assign unboxed_o = unboxed_r;

endmodule

// File: tb/tb_bp_be_fp_recode_pipe.sv
// Directed bench for bp_be_fp_recode_pipe.
module tb_bp_be_fp_recode_pipe;
  import bp_be_pkg::*;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          v_i;
  logic          ready_and_o;
  logic [63:0]   data_i;
  bp_be_fp_tag_e tag_i;
  logic [4:0]    rd_addr_i;
  logic          flush_i;
  logic          v_o;
  logic          ready_and_i;
  logic [65:0]   data_o;
  logic [4:0]    rd_addr_o;
  logic          unboxed_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  bp_be_fp_recode_pipe dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .ready_and_o (ready_and_o),
    .data_i      (data_i),
    .tag_i       (tag_i),
    .rd_addr_i   (rd_addr_i),
    .flush_i     (flush_i),
    .v_o         (v_o),
    .ready_and_i (ready_and_i),
    .data_o      (data_o),
    .rd_addr_o   (rd_addr_o),
    .unboxed_o   (unboxed_o)
  );

  task automatic chk(input string name, input logic [65:0] obs, input logic [65:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One isolated transaction through an empty pipe with ready_and_i high
  task automatic single(input string name, input logic [63:0] d, input bp_be_fp_tag_e t,
                        input logic [4:0] rd, input logic [65:0] exp_d, input logic exp_unb);
    v_i = 1'b1; data_i = d; tag_i = t; rd_addr_i = rd; ready_and_i = 1'b1;
    tick();
    v_i = 1'b0;
    chk({name, "_v_lat1"}, 66'(v_o), 66'd0);
    tick();
    chk({name, "_v"},       66'(v_o), 66'd1);
    chk({name, "_data"},    data_o, exp_d);
    chk({name, "_unboxed"}, 66'(unboxed_o), 66'(exp_unb));
    chk({name, "_rd"},      66'(rd_addr_o), 66'(rd));
  endtask

  logic [65:0] expq[$];
  logic [4:0]  rdq[$];
  int          sent, recv;
  bit          saw_stall;

  initial begin
    reset_i = 1'b1; v_i = 1'b0; data_i = '0; tag_i = e_fp_dp; rd_addr_i = '0;
    flush_i = 1'b0; ready_and_i = 1'b1;
    tick(); tick();
    chk("rst_v_o",     66'(v_o), 66'd0);
    chk("rst_ready",   66'(ready_and_o), 66'd1);
    chk("rst_data",    data_o, 66'd0);
    chk("rst_rd",      66'(rd_addr_o), 66'd0);
    chk("rst_unboxed", 66'(unboxed_o), 66'd0);
    reset_i = 1'b0;
    tick();

    single("dp_one",     64'h3ff00000_00000000, e_fp_dp, 5'd1,  66'h0_80000000_00000000, 1'b0);
    single("sp_one",     64'hffffffff_3f800000, e_fp_sp, 5'd2,  66'h2_80000000_00000000, 1'b0);
    single("sp_unboxed", 64'h00000000_3f800000, e_fp_sp, 5'd3,  66'h2_e0080000_00000000, 1'b1);
    single("sp_minsub",  64'hffffffff_00000001, e_fp_sp, 5'd4,  66'h2_76b00000_00000000, 1'b0);
    single("dp_negzero", 64'h80000000_00000000, e_fp_dp, 5'd5,  66'h1_00000000_00000000, 1'b0);
    single("dp_qnan",    64'h7ff80000_00000000, e_fp_dp, 5'd6,  66'h0_e0080000_00000000, 1'b0);
    single("dp_minsub",  64'h00000000_00000001, e_fp_dp, 5'd7,  66'h0_3ce00000_00000000, 1'b0);
    single("dp_inf",     64'h7ff00000_00000000, e_fp_dp, 5'd8,  66'h0_c0000000_00000000, 1'b0);
    single("sp_inf",     64'hffffffff_7f800000, e_fp_sp, 5'd9,  66'h2_c0000000_00000000, 1'b0);
    single("sp_neg_two", 64'hffffffff_c0000000, e_fp_sp, 5'd10, 66'h3_80100000_00000000, 1'b0);
    single("sp_qnan",    64'hffffffff_7fc00000, e_fp_sp, 5'd11, 66'h2_e0080000_00000000, 1'b0);
    single("sp_maxsub",  64'hffffffff_00400000, e_fp_sp, 5'd12, 66'h2_78100000_00000000, 1'b0);
    single("dp_2p5",     64'h40040000_00000000, e_fp_dp, 5'd13, 66'h0_80140000_00000000, 1'b0);
    tick();

    // Back-to-back stream with a three-cycle downstream stall
    sent = 0; recv = 0; saw_stall = 1'b0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      v_i         = (sent < 6);
      data_i      = {1'b0, 11'(1023 + sent), 52'(sent)};
      tag_i       = e_fp_dp;
      rd_addr_i   = 5'(sent);
      ready_and_i = !(c >= 3 && c <= 5);
      #1;
      if (!ready_and_o) saw_stall = 1'b1;
      if (v_o && ready_and_i) begin
        chk("stream_expected_pending", 66'(expq.size() > 0), 66'd1);
        if (expq.size() > 0) begin
          chk("stream_data", data_o, expq.pop_front());
          chk("stream_rd",   66'(rd_addr_o), 66'(rdq.pop_front()));
        end
        recv++;
      end
      if (v_i && ready_and_o) begin
        expq.push_back({1'b0, 1'b0, 12'(2048 + sent), 52'(sent)});
        rdq.push_back(5'(sent));
        sent++;
      end
      tick();
    end
    v_i = 1'b0; ready_and_i = 1'b1;
    chk("stream_recv_count", 66'(recv), 66'd6);
    chk("stream_stall_seen", 66'(saw_stall), 66'd1);
    chk("stream_no_dup",     66'(v_o), 66'd0);
    tick();

    // Flush with both stages full plus a new input offered
    ready_and_i = 1'b0;
    v_i = 1'b1; data_i = 64'h3ff00000_00000000; tag_i = e_fp_dp; rd_addr_i = 5'd20;
    tick();
    rd_addr_i = 5'd21;
    tick();
    chk("flush_pre_full_v", 66'(v_o), 66'd1);
    chk("flush_pre_ready",  66'(ready_and_o), 66'd0);
    flush_i = 1'b1; ready_and_i = 1'b1; rd_addr_i = 5'd22;
    tick();
    flush_i = 1'b0; v_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("flush_no_v_o", 66'(v_o), 66'd0);
      tick();
    end

    // Reset mid-stream
    v_i = 1'b1; rd_addr_i = 5'd25;
    tick();
    rd_addr_i = 5'd26;
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0; v_i = 1'b0;
    chk("midrst_v_o",   66'(v_o), 66'd0);
    chk("midrst_ready", 66'(ready_and_o), 66'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst_quiet", 66'(v_o), 66'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
